// File: rtl/i2c_sensor_master_if.sv
// Controller request/response and open-drain pad signals of the single-byte I2C sensor master.
interface i2c_sensor_master_if;
  logic       start;
  logic       mode;
  logic [6:0] sensorAddr;
  logic [7:0] writeVal;
  logic [7:0] readVal;
  logic       dataRdy;
  logic       busy;
  logic       ack_err;
  logic       scl;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  start, mode, sensorAddr, writeVal, sda_in,
    output readVal, dataRdy, busy, ack_err, scl, sda_oe
  );

  modport slave (
    output start, mode, sensorAddr, writeVal, sda_in,
    input  readVal, dataRdy, busy, ack_err, scl, sda_oe
  );
endinterface

// File: rtl/i2c_sensor_master.sv
// Single-byte I2C master: one address byte, then one data byte written or read, quarter-bit timed.
// SCL and SDA enable are computed from the next state and registered, so the pads never glitch.
module i2c_sensor_master #(
  parameter int CLK_DIV = 4
) (
  input  logic                       clock,
  input  logic                       rst_n,
  i2c_sensor_master_if.master        bus
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, STOP, DONE
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_t     state, state_d;
  logic [7:0] div_cnt, div_d;
  logic [1:0] quarter, quarter_d;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] addr_byte;   // {sensorAddr, mode}; bit 0 doubles as the latched direction
  logic [7:0] wdata;
  logic [7:0] shift;
  logic       scl_d, sda_oe_d;
  logic       quarter_tick, bit_end, sample_pt;

  assign quarter_tick = (div_cnt == DIV_MAX);
  assign bit_end      = quarter_tick && (quarter == 2'd3);
  assign sample_pt    = quarter_tick && (quarter == 2'd2);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      quarter <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      quarter <= quarter_d;
      bit_cnt <= bit_d;
    end
  end

  // NOTE: every combinational output is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    div_d     = div_cnt;
    quarter_d = quarter;
    bit_d     = bit_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d   = START;
          div_d     = '0;
          quarter_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (quarter_tick) begin
          div_d     = '0;
          quarter_d = quarter + 2'd1;
        end else begin
          div_d = div_cnt + 8'd1;
        end
        if (bit_end) begin
          case (state)
            START: begin
              state_d = ADDR;
              bit_d   = 3'd7;
            end
            ADDR: begin
              if (bit_cnt == 3'd0) state_d = ACK1;
              else                 bit_d   = bit_cnt - 3'd1;
            end
            ACK1: begin
              // ack_err was set at the q2 sample of this slot on a NACK
              if (ack_err_q()) begin
                state_d = STOP;
              end else begin
                state_d = addr_byte[0] ? RDATA : WDATA;
                bit_d   = 3'd7;
              end
            end
            WDATA, RDATA: begin
              if (bit_cnt == 3'd0) state_d = ACK2;
              else                 bit_d   = bit_cnt - 3'd1;
            end
            ACK2:    state_d = STOP;
            STOP:    state_d = DONE;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  function automatic logic ack_err_q();
    return bus.ack_err;
  endfunction

  // Pad levels for the cycle we are about to enter.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      START: begin
        scl_d    = ~quarter_d[1];
        sda_oe_d = (quarter_d != 2'd0);
      end
      ADDR: begin
        scl_d    = quarter_d[0] ^ quarter_d[1];
        sda_oe_d = ~addr_byte[bit_d];
      end
      WDATA: begin
        scl_d    = quarter_d[0] ^ quarter_d[1];
        sda_oe_d = ~wdata[bit_d];
      end
      ACK1, RDATA, ACK2: begin
        scl_d    = quarter_d[0] ^ quarter_d[1];
        sda_oe_d = 1'b0;
      end
      STOP: begin
        scl_d    = (quarter_d != 2'd0);
        sda_oe_d = ~quarter_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // NOTE: the latched request and shift register are reset too; they are a few flops, not a memory.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.scl     <= 1'b1;
      bus.sda_oe  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.dataRdy <= 1'b0;
      bus.ack_err <= 1'b0;
      bus.readVal <= 8'h00;
      addr_byte   <= 8'h00;
      wdata       <= 8'h00;
      shift       <= 8'h00;
    end else begin
      bus.scl     <= scl_d;
      bus.sda_oe  <= sda_oe_d;
      bus.busy    <= (state_d != IDLE);
      bus.dataRdy <= (state_d == DONE);
      if (state == IDLE && bus.start) begin
        addr_byte   <= {bus.sensorAddr, bus.mode};
        wdata       <= bus.writeVal;
        bus.ack_err <= 1'b0;
      end
      if (sample_pt) begin
        case (state)
          ACK1:    if (bus.sda_in) bus.ack_err <= 1'b1;
          ACK2:    if (!addr_byte[0] && bus.sda_in) bus.ack_err <= 1'b1;
          RDATA:   shift <= {shift[6:0], bus.sda_in};
          default: ;
        endcase
      end
      if (state == STOP && state_d == DONE && addr_byte[0] && !bus.ack_err) begin
        bus.readVal <= shift;
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_master.sv
// Self-checking bench: a per-cycle trace built from the bit-level protocol rules is compared every cycle,
// an open-drain bus monitor decodes bytes/START/STOP, and directed cases pin literal expectations.
module tb_i2c_sensor_master;
  localparam int CLK_DIV = 4;
  localparam int FULL_CYC = 80 * CLK_DIV + 1;
  localparam int NACK_CYC = 44 * CLK_DIV + 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic slave_pull = 1'b0;
  logic nxt_ack1 = 1'b1, nxt_ack2 = 1'b1;
  logic [7:0] nxt_rdata = 8'h00;

  i2c_sensor_master_if bus ();

  i2c_sensor_master #(.CLK_DIV(CLK_DIV)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Wired-AND SDA line: low if either master or slave pulls.
  assign bus.sda_in = ~bus.sda_oe & ~slave_pull;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: expected per-cycle trace ----------------
  typedef struct packed {
    logic idle;
    logic scl;
    logic oe;
    logic busy;
    logic rdy;
    logic pull;
    logic chk;
  } cyc_t;

  localparam cyc_t IDLE_C = '{idle: 1'b1, scl: 1'b1, oe: 1'b0, busy: 1'b0, rdy: 1'b0, pull: 1'b0, chk: 1'b1};

  cyc_t       exp_q[$];
  cyc_t       cur = IDLE_C;
  logic       exp_ack = 1'b0;
  logic [7:0] exp_rv = 8'h00;

  task automatic push_q(input logic s, input logic o, input logic p);
    cyc_t c;
    c = '{idle: 1'b0, scl: s, oe: o, busy: 1'b1, rdy: 1'b0, pull: p, chk: 1'b0};
    repeat (CLK_DIV) exp_q.push_back(c);
  endtask

  task automatic push_slot(input logic o, input logic p);
    push_q(1'b0, o, p);
    push_q(1'b1, o, p);
    push_q(1'b1, o, p);
    push_q(1'b0, o, p);
  endtask

  task automatic build(input logic md, input logic [6:0] a, input logic [7:0] wv,
                       input logic a1, input logic a2, input logic [7:0] rd);
    logic [7:0] ab;
    cyc_t done_c;
    ab = {a, md};
    push_q(1'b1, 1'b0, 1'b0);
    push_q(1'b1, 1'b1, 1'b0);
    push_q(1'b0, 1'b1, 1'b0);
    push_q(1'b0, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) push_slot(!ab[i], 1'b0);
    push_slot(1'b0, a1);
    if (a1) begin
      for (int i = 7; i >= 0; i--) begin
        if (md) push_slot(1'b0, !rd[i]);
        else    push_slot(!wv[i], 1'b0);
      end
      push_slot(1'b0, md ? 1'b0 : a2);
    end
    push_q(1'b0, 1'b1, 1'b0);
    push_q(1'b1, 1'b1, 1'b0);
    push_q(1'b1, 1'b0, 1'b0);
    push_q(1'b1, 1'b0, 1'b0);
    done_c = '{idle: 1'b0, scl: 1'b1, oe: 1'b0, busy: 1'b1, rdy: 1'b1, pull: 1'b0, chk: 1'b1};
    exp_q.push_back(done_c);
    exp_ack = md ? !a1 : (!a1 || !a2);
    if (md && a1) exp_rv = rd;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        cur     = IDLE_C;
        exp_ack = 1'b0;
        exp_rv  = 8'h00;
      end else begin
        if (cur.idle && bus.start)
          build(bus.mode, bus.sensorAddr, bus.writeVal, nxt_ack1, nxt_ack2, nxt_rdata);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_C;
      end
      slave_pull = cur.pull;
    end
  end

  // ---------------- compare process and bus monitor ----------------
  logic bits_q[$];
  int   start_cnt = 0, stop_cnt = 0;
  logic prev_scl = 1'b1, prev_line = 1'b1;

  always @(negedge clock) begin
    if (!rst_n) begin
      check("reset_outputs", {bus.scl, bus.sda_oe, bus.busy, bus.dataRdy, bus.ack_err, bus.readVal},
            {5'b10000, 8'h00});
    end else begin
      check("cycle", {bus.scl, bus.sda_oe, bus.busy, bus.dataRdy}, {cur.scl, cur.oe, cur.busy, cur.rdy});
      if (cur.chk) check("status", {bus.ack_err, bus.readVal}, {exp_ack, exp_rv});
    end
    if (bus.scl && !prev_scl) bits_q.push_back(bus.sda_in);
    if (bus.scl && prev_scl && prev_line && !bus.sda_in) start_cnt++;
    if (bus.scl && prev_scl && !prev_line && bus.sda_in) stop_cnt++;
    prev_scl  = bus.scl;
    prev_line = bus.sda_in;
  end

  function automatic logic [7:0] bus_byte(input int off);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      r = {r[6:0], (off + i < bits_q.size()) ? bits_q[off + i] : 1'bx};
    return r;
  endfunction

  task automatic clear_mon();
    bits_q.delete();
    start_cnt = 0;
    stop_cnt  = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_rdy(input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (bus.dataRdy) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout actual=none expected=dataRdy within %0d cycles", budget);
    end
  endtask

  task automatic run_txn(input logic md, input logic [6:0] a, input logic [7:0] wv,
                         input logic a1, input logic a2, input logic [7:0] rd, output int cyc);
    int guard;
    guard = 0;
    @(negedge clock);
    while (bus.busy && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    bus.mode       = md;
    bus.sensorAddr = a;
    bus.writeVal   = wv;
    nxt_ack1       = a1;
    nxt_ack2       = a2;
    nxt_rdata      = rd;
    bus.start      = 1'b1;
    wait_rdy(FULL_CYC + 20, cyc);
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic md, a1, a2;
    logic [6:0] a;
    logic [7:0] wv, rd;

    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.sensorAddr = 7'h00;
    bus.writeVal   = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_state", {bus.scl, bus.sda_oe, bus.busy, bus.dataRdy, bus.ack_err, bus.readVal},
          {5'b10000, 8'h00});
    rst_n = 1'b1;
    @(negedge clock);

    // Write 0x48 / 0xA5, both bytes ACKed
    clear_mon();
    run_txn(1'b0, 7'h48, 8'hA5, 1'b1, 1'b1, 8'h00, cyc);
    check("wr_rdy_cycle", cyc, 321);
    check("wr_addr_byte", bus_byte(0), 8'h90);
    check("wr_data_byte", bus_byte(9), 8'hA5);
    check("wr_start_cnt", start_cnt, 1);
    check("wr_stop_cnt", stop_cnt, 1);
    check("wr_ack_err", bus.ack_err, 0);
    check("wr_readval", bus.readVal, 8'h00);

    // Read 0x48, slave returns 0x3C
    clear_mon();
    run_txn(1'b1, 7'h48, 8'h00, 1'b1, 1'b1, 8'h3C, cyc);
    check("rd_rdy_cycle", cyc, 321);
    check("rd_addr_byte", bus_byte(0), 8'h91);
    check("rd_data_on_bus", bus_byte(9), 8'h3C);
    check("rd_master_nack", bits_q[17], 1);
    check("rd_readval", bus.readVal, 8'h3C);
    check("rd_ack_err", bus.ack_err, 0);

    // Address NACK
    clear_mon();
    run_txn(1'b0, 7'h48, 8'h11, 1'b0, 1'b1, 8'h00, cyc);
    check("an_rdy_cycle", cyc, 177);
    check("an_scl_rises", bits_q.size(), 10);
    check("an_stop_cnt", stop_cnt, 1);
    check("an_ack_err", bus.ack_err, 1);
    check("an_readval", bus.readVal, 8'h3C);

    // Write with data NACK
    run_txn(1'b0, 7'h48, 8'h66, 1'b1, 1'b0, 8'h00, cyc);
    check("dn_rdy_cycle", cyc, 321);
    check("dn_ack_err", bus.ack_err, 1);

    // start held high, writeVal changed mid-transaction
    @(negedge clock);
    clear_mon();
    bus.mode       = 1'b0;
    bus.sensorAddr = 7'h21;
    bus.writeVal   = 8'h5A;
    nxt_ack1       = 1'b1;
    nxt_ack2       = 1'b1;
    bus.start      = 1'b1;
    repeat (100) @(negedge clock);
    bus.writeVal = 8'hC3;
    wait_rdy(400, cyc);
    check("held_first_rdy", cyc, 221);
    @(negedge clock);
    check("held_gap_idle", bus.busy, 0);
    @(negedge clock);
    check("held_reaccept", bus.busy, 1);
    wait_rdy(400, cyc);
    check("held_second_rdy", cyc, 320);
    bus.start = 1'b0;
    check("held_first_data", bus_byte(9), 8'h5A);
    check("held_second_data", bus_byte(19 + 9), 8'hC3);

    // Reset asserted during RDATA
    @(negedge clock);
    bus.mode       = 1'b1;
    bus.sensorAddr = 7'h33;
    nxt_ack1       = 1'b1;
    nxt_rdata      = 8'hE7;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (199) @(negedge clock);
    check("rst_pre_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {bus.scl, bus.sda_oe, bus.busy}, 3'b100);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    check("rst_readval", bus.readVal, 8'h00);
    run_txn(1'b1, 7'h33, 8'h00, 1'b1, 1'b1, 8'hE7, cyc);
    check("rst_read_rdy", cyc, 321);
    check("rst_read_val", bus.readVal, 8'hE7);

    // Randomized transactions checked against the trace model
    for (int n = 0; n < 24; n++) begin
      md = 1'($urandom_range(0, 1));
      a  = 7'($urandom);
      wv = 8'($urandom);
      rd = 8'($urandom);
      a1 = ($urandom_range(0, 5) != 0);
      a2 = ($urandom_range(0, 5) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_txn(md, a, wv, a1, a2, rd, cyc);
      check("rand_rdy_cycle", cyc, a1 ? FULL_CYC : NACK_CYC);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
